// File: rtl/mem_1rw_arb_pkg.sv
// Shared types and the round-robin pick function for mem_1rw_arb.
// The zero-fill state is only used when MEM_1RW_ARB_INIT_EN is defined.
package mem_1rw_arb_pkg;

    typedef enum logic {INIT, RUN} arb_state_e;

    // Modules narrow these to their own NREQ; $clog2(NREQ) gives the index width.
    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDX_W = $clog2(MAX_NREQ);

    // One-hot grant to the first set bit of valid at or after ptr, wrapping at nreq.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0]  valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   nreq
    );
        logic [MAX_NREQ-1:0]  grant;
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = MAX_IDX_W'((int'(ptr) + k) % nreq);
            if (k < nreq && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mem_1rw_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus the rotating priority pointer.
module rr_arbiter
    import mem_1rw_arb_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  valid,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner,
    output logic             granted
);

    logic [MAX_NREQ-1:0] valid_ext;
    logic [MAX_NREQ-1:0] pick;
    logic [IDX_W-1:0]    rr_ptr;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, MAX_IDX_W'(rr_ptr), NREQ);
        grant                 = enable ? pick[NREQ-1:0] : '0;
        granted               = enable & (|pick);
        winner                = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    // Priority moves just past the last winner; it holds when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/mem_1rw_arb.sv
// Shares one 1RW synchronous RAM between NREQ requesters and routes read data back.
// Define MEM_1RW_ARB_INIT_EN to zero-fill the RAM after every reset.
module mem_1rw_arb
    import mem_1rw_arb_pkg::*;
#(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = 5,
    parameter  int DATA_W = 64,
    localparam int IDX_W  = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_wmode,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     busy_init,
    output logic [ADDR_W-1:0]        RW0_addr,
    output logic                     RW0_en,
    output logic                     RW0_clk,
    output logic                     RW0_wmode,
    output logic [DATA_W-1:0]        RW0_wdata,
    input  logic [DATA_W-1:0]        RW0_rdata
);

    arb_state_e       state;
    logic             run_en;
    logic             granted;
    logic [IDX_W-1:0] winner;
    logic             pend;
    logic [IDX_W-1:0] pend_id;

`ifdef MEM_1RW_ARB_INIT_EN
    arb_state_e        state_next;
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == '1) begin
            state_next = RUN;
        end
    end

    assign busy_init = (state == INIT);
`else
    assign state     = RUN;
    assign busy_init = 1'b0;
`endif

    // Grants are held off while reset is asserted so nothing reaches the RAM.
    assign run_en = (state == RUN) && !reset;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .enable  (run_en),
        .valid   (req_valid),
        .grant   (req_ready),
        .winner  (winner),
        .granted (granted)
    );

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;
`ifdef MEM_1RW_ARB_INIT_EN
        if (state == INIT && !reset) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt;
        end
`endif
        if (granted) begin
            RW0_en    = 1'b1;
            RW0_wmode = req_wmode[winner];
            RW0_addr  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
            RW0_wdata = req_wdata[int'(winner)*DATA_W +: DATA_W];
        end
    end

    // RAM read data lands one cycle after the enable, so remember who asked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_id <= '0;
        end else begin
            pend    <= granted && !RW0_wmode;
            pend_id <= winner;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (pend) begin
            resp_valid[pend_id] = 1'b1;
        end
    end

    assign resp_rdata = RW0_rdata;
    assign RW0_clk    = clock;

endmodule

// File: tb/tb_mem_1rw_arb.sv
// Directed bench for mem_1rw_arb with a behavioural 1RW RAM and a response scoreboard.
module tb_mem_1rw_arb;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_wmode;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        resp_valid;
    logic [DATA_W-1:0]      resp_rdata;
    logic                   busy_init;
    logic [ADDR_W-1:0]      RW0_addr;
    logic                   RW0_en;
    logic                   RW0_clk;
    logic                   RW0_wmode;
    logic [DATA_W-1:0]      RW0_wdata;
    logic [DATA_W-1:0]      RW0_rdata = '0;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          tests_run = 0;
    int          fail_cnt = 0;
    logic [63:0] mem [DEPTH];

`ifdef MEM_1RW_ARB_INIT_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    always #5 clock = ~clock;

    mem_1rw_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wmode  (req_wmode),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy_init  (busy_init),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_clk    (RW0_clk),
        .RW0_wmode  (RW0_wmode),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata)
    );

    // Non-zero power-up contents so the zero-fill sweep is visible.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hA5A5_5A5A_C3C3_3C3C;
    end

    always @(posedge RW0_clk) begin
        if (RW0_en) begin
            if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
            else           RW0_rdata     <= mem[RW0_addr];
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Each expected response is due on the first falling edge after its grant edge.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check_output("resp_valid", 64'(resp_valid), 64'(1) << e.id);
            check_output("resp_rdata", resp_rdata, e.data);
        end else if (resp_valid != '0) begin
            tests_run++;
            fail_cnt++;
            $display("[TB] FAIL unexpected_resp: resp_valid=%b, required 00", resp_valid);
        end
    end

    task automatic set_req(input int i, input logic v, input logic w, input logic [4:0] a, input logic [63:0] d);
        req_valid[i]               = v;
        req_wmode[i]               = w;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Checks one cycle's grant and RAM port, queues any read response, then ends the cycle.
    task automatic apply_stimulus(input string name, input logic [1:0] exp_ready, input logic [4:0] exp_addr,
                                  input logic push_rd, input logic [63:0] exp_data);
        int w;
        #1;
        check_output({name, ":req_ready"}, 64'(req_ready), 64'(exp_ready));
        check_output({name, ":RW0_en"}, 64'(RW0_en), 64'(|exp_ready));
        check_output({name, ":RW0_addr"}, 64'(RW0_addr), 64'(exp_addr));
        if (exp_ready != 2'b00) begin
            w = exp_ready[1] ? 1 : 0;
            check_output({name, ":RW0_wmode"}, 64'(RW0_wmode), 64'(req_wmode[w]));
            check_output({name, ":RW0_wdata"}, RW0_wdata, req_wdata[w*DATA_W +: DATA_W]);
            if (push_rd) sb_q.push_back('{id: w, data: exp_data, due: cyc + 1});
        end else begin
            check_output({name, ":RW0_wmode"}, 64'(RW0_wmode), 64'(0));
            check_output({name, ":RW0_wdata"}, RW0_wdata, 64'(0));
        end
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wmode = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef MEM_1RW_ARB_INIT_EN
        set_req(0, 1'b1, 1'b0, 5'd0, 64'd0);
        set_req(1, 1'b1, 1'b0, 5'd31, 64'd0);
`else
        set_req(0, 1'b1, 1'b1, 5'd0, 64'd0);
        set_req(1, 1'b1, 1'b1, 5'd31, 64'd0);
`endif
        repeat (2) @(negedge clock);
        #1;
        check_output("rst:req_ready", 64'(req_ready), 64'(0));
        check_output("rst:RW0_en", 64'(RW0_en), 64'(0));
        check_output("rst:resp_valid", 64'(resp_valid), 64'(0));
        check_output("rst:busy_init", 64'(busy_init), 64'(EXP_BUSY_RST));
        @(negedge clock);
        reset = 1'b0;

`ifdef MEM_1RW_ARB_INIT_EN
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            check_output("init:busy_init", 64'(busy_init), 64'(1));
            check_output("init:req_ready", 64'(req_ready), 64'(0));
            check_output("init:RW0_en", 64'(RW0_en), 64'(1));
            check_output("init:RW0_wmode", 64'(RW0_wmode), 64'(1));
            check_output("init:RW0_addr", 64'(RW0_addr), 64'(c));
            check_output("init:RW0_wdata", RW0_wdata, 64'(0));
            @(negedge clock);
        end
`else
        apply_stimulus("zero_wr0", 2'b01, 5'd0, 1'b0, 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        apply_stimulus("zero_wr31", 2'b10, 5'd31, 1'b0, 64'd0);
`endif
        check_output("run:busy_init", 64'(busy_init), 64'(0));
        set_req(0, 1'b1, 1'b0, 5'd0, 64'd0);
        set_req(1, 1'b1, 1'b0, 5'd31, 64'd0);
        apply_stimulus("rd0", 2'b01, 5'd0, 1'b1, 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        apply_stimulus("rd31", 2'b10, 5'd31, 1'b1, 64'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 64'd0);

        set_req(0, 1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        apply_stimulus("wr5", 2'b01, 5'd5, 1'b0, 64'd0);
        set_req(0, 1'b1, 1'b0, 5'd5, 64'd0);
        apply_stimulus("rd5", 2'b01, 5'd5, 1'b1, 64'hDEAD_BEEF_0000_0001);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);

        set_req(0, 1'b1, 1'b1, 5'd1, 64'h11);
        apply_stimulus("wr1", 2'b01, 5'd1, 1'b0, 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        set_req(1, 1'b1, 1'b1, 5'd2, 64'h22);
        apply_stimulus("wr2", 2'b10, 5'd2, 1'b0, 64'd0);
        set_req(0, 1'b1, 1'b0, 5'd1, 64'd0);
        set_req(1, 1'b1, 1'b0, 5'd2, 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) apply_stimulus("alt_rd1", 2'b01, 5'd1, 1'b1, 64'h11);
            else            apply_stimulus("alt_rd2", 2'b10, 5'd2, 1'b1, 64'h22);
        end

        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        set_req(1, 1'b1, 1'b1, 5'd9, 64'h77);
        apply_stimulus("wr9", 2'b10, 5'd9, 1'b0, 64'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 64'd0);
        set_req(0, 1'b1, 1'b0, 5'd9, 64'd0);
        apply_stimulus("raw9", 2'b01, 5'd9, 1'b1, 64'h77);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);

        for (int k = 0; k < 10; k++) apply_stimulus("idle", 2'b00, 5'd0, 1'b0, 64'd0);
        set_req(0, 1'b1, 1'b1, 5'd20, 64'h20);
        set_req(1, 1'b1, 1'b1, 5'd21, 64'h21);
        apply_stimulus("ptr_hold", 2'b10, 5'd21, 1'b0, 64'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 64'd0);
        apply_stimulus("wr20", 2'b01, 5'd20, 1'b0, 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);

        // Read is granted, then reset lands before its response cycle.
        set_req(0, 1'b1, 1'b0, 5'd5, 64'd0);
        #1;
        check_output("mid:req_ready", 64'(req_ready), 64'(2'b01));
        @(posedge clock);
        #2;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        @(negedge clock);
        #1;
        check_output("mid:resp_valid", 64'(resp_valid), 64'(0));
        check_output("mid:busy_init", 64'(busy_init), 64'(EXP_BUSY_RST));
        @(negedge clock);
        reset = 1'b0;
`ifdef MEM_1RW_ARB_INIT_EN
        repeat (DEPTH) @(negedge clock);
`endif
        set_req(0, 1'b1, 1'b1, 5'd22, 64'h2222);
        set_req(1, 1'b1, 1'b1, 5'd23, 64'h2323);
        apply_stimulus("ptr_reset", 2'b01, 5'd22, 1'b0, 64'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0);
        apply_stimulus("after_reset", 2'b10, 5'd23, 1'b0, 64'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 64'd0);

        repeat (3) @(negedge clock);
        check_output("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_1rw_arb.md
# mem_1rw_arb

Round-robin arbiter and sequencer that shares one single-port synchronous RAM (the 1RW `RW0_*` macro, default 32x64) between `NREQ` requesters. It sits between the requester logic and the RAM wrapper. It serialises read/write requests onto the single RW port, routes the 1-cycle-late read data back to the requester that issued the read, and optionally zero-fills the RAM after reset.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `ADDR_W`, 5: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 64: RAM data width.

Ports:
- `clock` in 1: single clock; also drives `RW0_clk`.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: grant; transfer occurs on `req_valid[i] & req_ready[i]`.
- `req_addr` in NREQ*ADDR_W: packed addresses; requester i occupies slice i.
- `req_wmode` in NREQ: 1 = write, 0 = read.
- `req_wdata` in NREQ*DATA_W: packed write data.
- `resp_valid` out NREQ: read data valid for requester i, one-cycle pulse.
- `resp_rdata` out DATA_W: read data, shared by all requesters, qualified by `resp_valid`.
- `busy_init` out 1: zero-fill sweep in progress.
- `RW0_addr` out ADDR_W, `RW0_en` out 1, `RW0_clk` out 1, `RW0_wmode` out 1, `RW0_wdata` out DATA_W: RAM port.
- `RW0_rdata` in DATA_W: RAM read data, valid the cycle after a read enable.

## Operation
- FSM states: `INIT`, `RUN`. Reset enters `INIT` if `MEM_1RW_ARB_INIT_EN` is defined; otherwise it enters `RUN`.
- `INIT`:
  - `RW0_en=1`, `RW0_wmode=1`, `RW0_wdata=0`, `RW0_addr=init_cnt`.
  - `init_cnt` counts 0 to 2^ADDR_W-1, then the FSM moves to `RUN`.
  - `req_ready` = 0 and `busy_init` = 1 throughout.
- `RUN`:
  - Each cycle the block grants at most one requester with `req_valid` set.
  - Search order starts at `rr_ptr` and wraps modulo NREQ.
  - `req_ready` is one-hot to the winner. It is combinational from `req_valid` and `rr_ptr`.
  - On a transfer: `RW0_en=1`, and `RW0_addr`, `RW0_wmode` and `RW0_wdata` come from the winner. `rr_ptr` <= (winner+1) mod NREQ.
  - With no valid request: `RW0_en=0`, `rr_ptr` holds, and all other `RW0_*` outputs are 0.
- Read response:
  - On a read transfer, the winner index is registered with a pending flag.
  - Next cycle: `resp_valid[id]=1` and `resp_rdata=RW0_rdata`.
  - Requesters cannot backpressure responses. They must accept them.
- Writes produce no response.
- `RW0_clk = clock`.
- Reset values: `rr_ptr=0`, `init_cnt=0`, pending flag 0, `resp_valid=0`, `req_ready=0`, `RW0_en=0`, `busy_init` = 1 if INIT_EN is defined, else 0.
- Reset mid-operation: any pending read response is dropped with no `resp_valid` pulse. If INIT_EN is defined, the sweep restarts from address 0.

## Timing
- Request to RAM: 0 cycles. The RAM port is driven in the same cycle as the handshake.
- Read response: `resp_valid` rises exactly 1 cycle after the read handshake.
- Full throughput: one access per cycle; back-to-back reads give back-to-back responses.
- Read after write to the same address, from any requester, in the next cycle: returns the new data, because the RAM write completes at the edge.
- Simultaneous requests: the winner is the first set bit at or after `rr_ptr`. A requester that holds `req_valid` is granted within NREQ cycles.
- INIT sweep: exactly 2^ADDR_W cycles (32 by default). The first `req_ready` can assert on cycle 2^ADDR_W after reset release.
- Requesters must hold `req_*` stable while `req_valid` is high and not yet granted.

## Configuration
- `MEM_1RW_ARB_INIT_EN` defined: the post-reset zero-fill sweep is included; the `init_cnt` counter and `INIT` state exist.
- Not defined: the FSM is always in `RUN`, `busy_init` is tied to 0, and requests are accepted from the first cycle after reset release. RAM contents are then undefined.

## Structure
- Package `mem_1rw_arb_pkg`:
  - State enum `arb_state_e` {`INIT`, `RUN`}.
  - Function `rr_pick(valid, ptr)` returning the one-hot grant.
  - Localparam for the index width, `$clog2(NREQ)`.
- One sub-module: `rr_arbiter` contains the one-hot round-robin pick and the `rr_ptr` register. The top holds the FSM, the port mux and the response tracking.

## Test plan
- Reset with INIT_EN, hold all `req_valid` = 1 → `req_ready` = 0 for 32 cycles with `RW0_addr` 0..31 and `wdata` 0; then reads of addr 0 and addr 31 return 0.
- Req0 writes 0xDEADBEEF_00000001 to addr 5, then reads addr 5 → `resp_valid[0]` one cycle after the read grant, `resp_rdata` = 0xDEADBEEF_00000001, `resp_valid[1]` = 0.
- Both requesters continuously reading (req0 addr 1, req1 addr 2, contents 0x11 and 0x22) → grants alternate 0,1,0,1; responses alternate 0x11/0x22, one per cycle.
- Req1 writes 0x77 to addr 9 in cycle N; req0 reads addr 9 in cycle N+1 → `resp_rdata` = 0x77 in cycle N+2 on `resp_valid[0]`.
- Read granted, then `reset` asserted before the response cycle → no `resp_valid` pulse; `rr_ptr` returns to 0 and `busy_init` = 1.
- No requests for 10 cycles in `RUN` → `RW0_en` = 0 throughout, `rr_ptr` unchanged, `resp_valid` = 0.
